// File: rtl/rr_decoder_arbiter.sv
// rr_decoder_arbiter: round-robin owner selection for a shared 2-to-4 decoder,
// with a bounded hold time and a one-cycle break-before-make gap between owners.
`default_nettype none

module rr_decoder_arbiter #(
  parameter int MAX_HOLD = 8,
  parameter int HOLD_W   = 4
) (
  input  logic       clk_i,
  input  logic       reset_i,
  input  logic [3:0] req_i,
  input  logic       release_i,
  output logic       enable_o,
  output logic       addr0_o,
  output logic       addr1_o,
  output logic       timeout_o
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_GRANT = 2'd1;
  localparam logic [1:0] ST_GAP   = 2'd2;

  localparam logic [HOLD_W-1:0] HOLD_LIMIT = HOLD_W'(MAX_HOLD);

  logic [1:0]        state_q, state_d;
  logic [1:0]        owner_q, owner_d;
  logic [1:0]        ptr_q, ptr_d;
  logic [HOLD_W-1:0] cnt_q, cnt_d;
  logic              enable_q, enable_d;
  logic              timeout_q, timeout_d;

  logic       arb_hit;
  logic [1:0] arb_idx;
  logic       at_limit;
  logic       owner_req;
  logic       grant_exit;

  // Walk from the farthest offset back to ptr so the nearest set request wins.
  always_comb begin
    arb_hit = 1'b0;
    arb_idx = ptr_q;
    for (int i = 3; i >= 0; i--) begin
      if (req_i[ptr_q + 2'(i)]) begin
        arb_hit = 1'b1;
        arb_idx = ptr_q + 2'(i);
      end
    end
  end

  assign at_limit   = (cnt_q == HOLD_LIMIT);
  assign owner_req  = req_i[owner_q];
  assign grant_exit = release_i | ~owner_req | at_limit;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q   <= ST_IDLE;
      owner_q   <= 2'd0;
      ptr_q     <= 2'd0;
      cnt_q     <= '0;
      enable_q  <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      owner_q   <= owner_d;
      ptr_q     <= ptr_d;
      cnt_q     <= cnt_d;
      enable_q  <= enable_d;
      timeout_q <= timeout_d;
    end
  end

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE, ST_GAP: begin
        if (arb_hit) begin
          state_d = ST_GRANT;
          owner_d = arb_idx;
          cnt_d   = HOLD_W'(1);
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_GRANT: begin
        if (grant_exit) begin
          state_d = ST_GAP;
          ptr_d   = owner_q + 2'd1;
        end else begin
          cnt_d = cnt_q + HOLD_W'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Outputs are decoded from next state so they land on the same edge as the state.
  always_comb begin
    enable_d  = (state_d == ST_GRANT);
    timeout_d = (state_q == ST_GRANT) && at_limit && !release_i && owner_req;
  end

  assign enable_o  = enable_q;
  assign timeout_o = timeout_q;
  assign addr0_o   = owner_q[0];
  assign addr1_o   = owner_q[1];

endmodule

`default_nettype wire

// File: tb/tb_rr_decoder_arbiter.sv
// Vector-table bench for rr_decoder_arbiter with a small expected-output scoreboard.
`default_nettype none

module tb_rr_decoder_arbiter;

  typedef struct {
    logic       rst;
    logic [3:0] req;
    logic       rel;
    logic       en;
    logic [1:0] addr;
    logic       to;
  } vec_t;

  typedef struct {
    int         idx;
    logic       en;
    logic [1:0] addr;
    logic       to;
  } exp_t;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] req = 4'd0;
  logic       rel = 1'b0;
  logic       enable, addr0, addr1, timeout;

  vec_t vecs[$];
  exp_t exp_q[$];
  int   n_vec = 0;
  int   n_bad = 0;

  rr_decoder_arbiter #(.MAX_HOLD(8), .HOLD_W(4)) dut (
    .clk_i    (clk),
    .reset_i  (reset),
    .req_i    (req),
    .release_i(rel),
    .enable_o (enable),
    .addr0_o  (addr0),
    .addr1_o  (addr1),
    .timeout_o(timeout)
  );

  always #5 clk = ~clk;

  task automatic add(input logic r, input logic [3:0] q, input logic l,
                     input logic e, input logic [1:0] a, input logic t);
    vec_t v;
    v.rst = r; v.req = q; v.rel = l; v.en = e; v.addr = a; v.to = t;
    vecs.push_back(v);
  endtask

  task automatic apply(input vec_t v, input int idx);
    exp_t x, got;
    @(negedge clk);
    reset = v.rst;
    req   = v.req;
    rel   = v.rel;
    x.idx = idx; x.en = v.en; x.addr = v.addr; x.to = v.to;
    exp_q.push_back(x);
    @(posedge clk);
    #1;
    got = exp_q.pop_front();
    n_vec++;
    if (enable !== got.en || {addr1, addr0} !== got.addr || timeout !== got.to) begin
      n_bad++;
      $display("FAIL vec%0d: got en=%b addr=%b%b to=%b, expected en=%b addr=%b to=%b",
               got.idx, enable, addr1, addr0, timeout, got.en, got.addr, got.to);
    end
  endtask

  initial begin
    // Reset held with all requests pending, then owner 0 first.
    add(1, 4'b1111, 0, 0, 2'd0, 0);
    add(1, 4'b1111, 0, 0, 2'd0, 0);
    add(0, 4'b1111, 0, 1, 2'd0, 0);
    // Fairness: release in the first cycle of each grant.
    add(0, 4'b1111, 1, 0, 2'd0, 0);
    add(0, 4'b1111, 0, 1, 2'd1, 0);
    add(0, 4'b1111, 1, 0, 2'd1, 0);
    add(0, 4'b1111, 0, 1, 2'd2, 0);
    add(0, 4'b1111, 1, 0, 2'd2, 0);
    add(0, 4'b1111, 0, 1, 2'd3, 0);
    add(0, 4'b1111, 1, 0, 2'd3, 0);
    add(0, 4'b1111, 0, 1, 2'd0, 0);
    add(0, 4'b1111, 1, 0, 2'd0, 0);
    add(0, 4'b0000, 0, 0, 2'd0, 0);
    // Single requester 2: three grant cycles, release, gap, regrant.
    add(0, 4'b0100, 0, 1, 2'd2, 0);
    add(0, 4'b0100, 0, 1, 2'd2, 0);
    add(0, 4'b0100, 0, 1, 2'd2, 0);
    add(0, 4'b0100, 1, 0, 2'd2, 0);
    add(0, 4'b0100, 0, 1, 2'd2, 0);
    // Request dropped mid-grant ends it on the next cycle.
    add(0, 4'b0000, 0, 0, 2'd2, 0);
    add(0, 4'b0000, 0, 0, 2'd2, 0);
    // Hold limit: eight grant cycles, timeout gap, regrant.
    for (int i = 0; i < 8; i++) add(0, 4'b0010, 0, 1, 2'd1, 0);
    add(0, 4'b0010, 0, 0, 2'd1, 1);
    add(0, 4'b0010, 0, 1, 2'd1, 0);
    // Release coincident with the limit: no timeout.
    for (int i = 0; i < 7; i++) add(0, 4'b0010, 0, 1, 2'd1, 0);
    add(0, 4'b0010, 1, 0, 2'd1, 0);
    add(0, 4'b0000, 0, 0, 2'd1, 0);
    // Reset in owner 3's fourth grant cycle; restart from pointer 0.
    for (int i = 0; i < 4; i++) add(0, 4'b1001, 0, 1, 2'd3, 0);
    add(1, 4'b1001, 0, 0, 2'd0, 0);
    add(0, 4'b1001, 0, 1, 2'd0, 0);

    foreach (vecs[i]) apply(vecs[i], i);

    // Hand sequence: owner 0 reaches the limit in the same cycle its request drops.
    begin
      vec_t v;
      v.rst = 0; v.rel = 0; v.req = 4'b0001; v.en = 1; v.addr = 2'd0; v.to = 0;
      for (int i = 0; i < 7; i++) apply(v, 100 + i);
      v.req = 4'b0000; v.en = 0;
      apply(v, 107);
      apply(v, 108);
      // Requester 2 from IDLE with ptr=1 gets a grant on the very next edge.
      v.req = 4'b0100; v.en = 1; v.addr = 2'd2;
      apply(v, 109);
      v.rel = 1; v.en = 0;
      apply(v, 110);
    end

    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL scoreboard: %0d entries left, expected 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
